// File: rtl/riscv_pkg.sv
// Shared RV32I control definitions: multicycle FSM states, opcodes,
// ALUOp codes and the datapath mux-select encodings.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/main_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable and mux select, stalling on MemReady.
module main_fsm
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       MemReady,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       AdrSrc,
  output logic [1:0] ALUOp,
  output logic [3:0] State
);

  state_t state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign State = state_q;

  always_comb begin
    state_d   = S_FETCH;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    AdrSrc    = 1'b0;
    ALUOp     = 2'b00;

    case (state_q)
      S_FETCH: begin
        state_d   = MemReady ? S_DECODE : S_FETCH;
        AdrSrc    = 1'b0;
        IRWrite   = MemReady;
        PCUpdate  = MemReady;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ALUOp     = ALUOP_ADD;
        ResultSrc = RES_ALURESULT;
      end
      S_DECODE: begin
        // Unsupported opcodes fall back to FETCH as a NOP; PC already moved.
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_FETCH;
        endcase
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
      end
      S_MEMADR: begin
        state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
      end
      S_MEMREAD: begin
        state_d   = MemReady ? S_MEMWB : S_MEMREAD;
        ResultSrc = RES_ALUOUT;
        AdrSrc    = 1'b1;
      end
      S_MEMWB: begin
        state_d   = S_FETCH;
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        state_d   = MemReady ? S_FETCH : S_MEMWRITE;
        ResultSrc = RES_ALUOUT;
        AdrSrc    = 1'b1;
        MemWrite  = 1'b1;
      end
      S_EXECUTER: begin
        state_d = S_ALUWB;
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        state_d = S_ALUWB;
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        state_d   = S_FETCH;
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
      end
      S_BEQ: begin
        state_d   = S_FETCH;
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        Branch    = 1'b1;
      end
      S_JAL: begin
        state_d   = S_ALUWB;
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ALUOp     = ALUOP_ADD;
        ResultSrc = RES_ALUOUT;
        PCUpdate  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset must kill enables combinationally so a stalled store never lands.
    if (reset) begin
      PCUpdate  = 1'b0;
      Branch    = 1'b0;
      RegWrite  = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      ResultSrc = RES_ALURESULT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_FOUR;
      AdrSrc    = 1'b0;
      ALUOp     = ALUOP_ADD;
    end
  end

endmodule

// File: doc/main_fsm.md
# main_fsm

Multicycle control state machine for the RV32I core. It decodes the 7-bit opcode of the instruction held in the instruction register and sequences the datapath through fetch, decode, execute, memory and writeback. It produces the 2-bit `ALUOp` consumed directly by `alu_decoder`, and every other datapath enable and mux select. Memory accesses stall on a ready handshake.

## Interface
- No parameters.
- `clk  in  1`: rising-edge clock.
- `reset  in  1`: asynchronous, active-high reset. State returns to FETCH immediately.
- `op  in  7`: opcode field of the instruction register. Only sampled in DECODE and MEMADR.
- `MemReady  in  1`: unified memory has completed the current read or write this cycle.
- `PCUpdate  out  1`: PC register write enable.
- `Branch  out  1`: branch evaluation. The datapath ORs `(Branch & Zero)` into the PC write.
- `RegWrite  out  1`: register file write enable.
- `MemWrite  out  1`: data memory write strobe.
- `IRWrite  out  1`: instruction register (and OldPC) write enable.
- `ResultSrc  out  2`: result select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA  out  2`: ALU A select. 00 = PC, 01 = OldPC, 10 = rs1 register.
- `ALUSrcB  out  2`: ALU B select. 00 = rs2 register, 01 = ImmExt, 10 = constant 4.
- `AdrSrc  out  1`: memory address select. 0 = PC, 1 = ALUOut.
- `ALUOp  out  2`: to `alu_decoder`. 00 = add, 01 = subtract, 10 = funct-decoded.
- `State  out  4`: current state encoding, for debug and verification.

## Operation
- States (4-bit encoding): FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11–15 are unreachable and return to FETCH.
- Transitions:
  - FETCH → DECODE if MemReady, else hold.
  - DECODE dispatches on op:
    - 0000011 (lw) or 0100011 (sw) → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other opcode → FETCH. The instruction is treated as a NOP; PC was already advanced in FETCH.
  - MEMADR: op=0000011 → MEMREAD, else → MEMWRITE.
  - MEMREAD → MEMWB if MemReady, else hold.
  - MEMWRITE → FETCH if MemReady, else hold.
  - MEMWB, ALUWB, BEQ → FETCH.
  - EXECUTER, EXECUTEI, JAL → ALUWB.
- Outputs are Moore, decoded from the state register. The only exception is that IRWrite and PCUpdate in FETCH are ANDed with MemReady. Any signal not listed for a state is 0.
  - FETCH: AdrSrc=0, IRWrite=MemReady, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=MemReady.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/jump target precompute).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. MemWrite stays high for every stalled cycle until MemReady.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
- While reset is high, all write enables are forced to 0: PCUpdate, IRWrite, RegWrite, MemWrite, Branch. Selects take their FETCH values.

## Timing
- Reset values: State=0, PCUpdate=0, IRWrite=0, RegWrite=0, MemWrite=0, Branch=0, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
- The state register updates on the rising edge of clk. Outputs are valid combinationally within the same cycle.
- Cycles per instruction with MemReady tied to 1:
  - lw 5, sw 4, R-type 4, I-type ALU 4, beq 3, jal 4, unsupported opcode 2.
- Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. No other state looks at MemReady.
- Reset asserted mid-instruction, including during a stalled MEMWRITE, drops MemWrite in the same cycle and returns to FETCH. No write completes.
- `op` changing outside DECODE and MEMADR has no effect.

## Structure
- A shared package `riscv_pkg` holds:
  - the state enum/localparams;
  - opcode constants OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL;
  - ALUOp constants ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10 (shared with `alu_decoder`);
  - the ResultSrc, ALUSrcA and ALUSrcB encodings.
- Single module with no sub-modules: one sequential state-register process and one combinational next-state/output process.

## Test plan
- Reset then lw (op=0000011), MemReady=1 → State sequence 0,1,2,3,4,0. RegWrite=1 only in state 4, with ResultSrc=01.
- sw (op=0100011), MemReady low for 3 cycles in MEMWRITE → MemWrite=1 for 4 consecutive cycles, then State=0.
- beq (op=1100011) → State sequence 0,1,9,0. In state 9: Branch=1, ALUOp=01. RegWrite stays 0 throughout.
- R-type (op=0110011) and I-type (op=0010011) → ALUOp=10 in states 6 and 7 respectively, with ALUSrcB=00 vs 01. State 8 then asserts RegWrite=1.
- Unsupported opcode 0110111, plus FETCH with MemReady=0 for 2 cycles → IRWrite=0 and PCUpdate=0 while stalled. Sequence is 0,0,0,1,0.
- Assert reset asynchronously mid-MEMWRITE → MemWrite=0 before the next clock edge. State=0, all enables 0 until reset deasserts.
